// File: rtl/shumezuesi_sekuencial_pkg.sv
// shumezuesi_sekuencial_pkg: shared state encodings and default width for the sequential multiplier
package shumezuesi_sekuencial_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LLOGARIT   = 2'd1,
    PERFUNDUAR = 2'd2
  } state_t;
endpackage

// File: rtl/shumezuesi_sekuencial_mbledhesi.sv
// mbledhesi_nbit: WIDTH-bit ripple-carry adder built as a chain of 1-bit full-adder cells
module mbledhesi_nbit
  import shumezuesi_sekuencial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  // carry ripples bit by bit through one full-adder cell per position
  always_comb begin
    logic cy;
    cy = cin;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end
endmodule

// File: rtl/shumezuesi_sekuencial.sv
// shumezuesi_sekuencial: unsigned shift-and-add multiplier, one multiplier bit per cycle
module shumezuesi_sekuencial
  import shumezuesi_sekuencial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] produkti
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_next;
  logic [CW-1:0] counter;
  logic [WIDTH-1:0] m, p_hi, p_lo, addend, s;
  logic c, last;
  logic [2*WIDTH-1:0] p_next;
  assign addend = p_lo[0] ? m : '0;
  mbledhesi_nbit #(.WIDTH(WIDTH)) u_add (
    .a(p_hi),
    .b(addend),
    .cin(1'b0),
    .sum(s),
    .cout(c)
  );
  // carry-out becomes the new top bit so the partial product is never truncated
  assign p_next = {c, s, p_lo[WIDTH-1:1]};
  assign last = counter == CW'(WIDTH - 1);
  assign busy = state == LLOGARIT;
  assign done = state == PERFUNDUAR;
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  // next state: accept in IDLE, iterate WIDTH times, one done cycle, back to IDLE
  always_comb begin
    state_next = (state == IDLE) ? (start ? LLOGARIT : IDLE) :
                 (state == LLOGARIT) ? (last ? PERFUNDUAR : LLOGARIT) : IDLE;
  end
  // datapath: latch operands on accept, shift-add each iteration, publish product on the last one
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      m <= '0;
      p_hi <= '0;
      p_lo <= '0;
      counter <= '0;
      produkti <= '0;
    end else if (state == IDLE && start) begin
      m <= a;
      p_hi <= '0;
      p_lo <= b;
      counter <= '0;
    end else if (state == LLOGARIT) begin
      {p_hi, p_lo} <= p_next;
      counter <= counter + 1'b1;
      if (last) produkti <= p_next;
    end
endmodule

// File: tb/tb_shumezuesi_sekuencial.sv
// tb_shumezuesi_sekuencial: directed and random checks of the sequential multiplier against a timing/arithmetic model
module tb_shumezuesi_sekuencial;
  localparam int W = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done;
  logic [2*W-1:0] produkti;
  int n_chk = 0, n_fail = 0;
  int left = 0;
  logic [W-1:0] ma = '0, mb = '0;
  logic [2*W-1:0] m_prod = '0;

  shumezuesi_sekuencial #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .produkti(produkti)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: an accepted start occupies WIDTH busy cycles plus one done cycle; product is plain a*b
  always @(posedge clock or posedge reset)
    if (reset) begin
      left = 0;
      m_prod = '0;
    end else if (left == 0) begin
      if (start) begin
        left = W + 1;
        ma = a;
        mb = b;
      end
    end else begin
      left--;
      if (left == 1) m_prod = (2*W)'(ma) * (2*W)'(mb);
    end

  always @(negedge clock) begin
    chk("busy", 64'(busy), 64'(left > 1));
    chk("done", 64'(done), 64'(left == 1));
    chk("produkti", 64'(produkti), 64'(m_prod));
    chk("busy_and_done", 64'(busy & done), 64'd0);
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] exp, input bit inj);
    int lat, bcnt;
    bit seen;
    a = x;
    b = y;
    start = 1'b1;
    lat = 0;
    bcnt = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
      end
      if (busy) bcnt++;
      if (inj && lat == 5) begin
        start = 1'b1;
        a = 16'h1234;
        b = 16'h0010;
      end
      if (inj && lat == 6) start = 1'b0;
      if (done) seen = 1;
    end
    chk("latency", 64'(lat), 64'(W + 1));
    chk("busy_cycles", 64'(bcnt), 64'(W));
    chk("product", 64'(produkti), 64'(exp));
    @(negedge clock);
  endtask

  initial begin
    int prev, ndone;
    logic [W-1:0] x, y;
    repeat (2) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_produkti", 64'(produkti), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    run_op(16'h0003, 16'h0005, 32'h0000000F, 0);
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
    run_op(16'h0000, 16'hBEEF, 32'h00000000, 0);
    run_op(16'h8000, 16'h0002, 32'h00010000, 0);
    run_op(16'h0007, 16'h0009, 32'h0000003F, 1);
    a = 16'h1111;
    b = 16'h0002;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    chk("pre_abort_busy", 64'(busy), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_produkti", 64'(produkti), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    run_op(16'h0002, 16'h0007, 32'h0000000E, 0);
    start = 1'b1;
    prev = -1;
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clock);
      if (done) begin
        if (prev >= 0) chk("b2b_interval", 64'(i - prev), 64'(W + 2));
        prev = i;
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", 64'(ndone), 64'd5);
    repeat (W + 3) @(negedge clock);
    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      run_op(x, y, (2*W)'(x) * (2*W)'(y), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
